qp_mem_arbiter: RTL and testbench

- Shares the single-port query-patch SRAM between two requesters:
  - the Wishbone slave controller (debug read/write of patches);
  - the ANN search engine (query streaming/writeback).
- Normal operation: round-robin grant, one access per cycle.
- Debug mode: engine locked out. Every mode change drains outstanding reads first, so no response ever goes to the wrong owner.
- Sits between wbsCtrl / engine and the qp SRAM macro.

---
 rtl/qp_arb_pkg.sv | 30 +++
 rtl/qp_rsp_pipe.sv | 37 +++
 rtl/qp_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_qp_mem_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/qp_arb_pkg.sv
// Shared types and sizing for the query-patch SRAM arbiter.
// Both requesters and the SRAM macro exchange whole patches.
package qp_arb_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int ROW_SIZE   = 24;
  localparam int COL_SIZE   = 17;
  localparam int ADDRW      = $clog2(ROW_SIZE * COL_SIZE);
  localparam int PATCHW     = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    NORMAL          = 2'd0,
    DRAIN_TO_DEBUG  = 2'd1,
    DEBUG           = 2'd2,
    DRAIN_TO_NORMAL = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_WBS = 1'b0,
    OWN_ENG = 1'b1
  } owner_e;

  typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

  function automatic logic is_drain(arb_state_e s);
    return (s == DRAIN_TO_DEBUG) || (s == DRAIN_TO_NORMAL);
  endfunction

endpackage

// File: rtl/qp_rsp_pipe.sv
// Two-stage valid+owner shift register that steers each read response
// to the requester that issued it, independent of the arbiter state.
module qp_rsp_pipe
  import qp_arb_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic push_i,
  input  logic owner_i,
  output logic wbs_rsp_valid_o,
  output logic eng_rsp_valid_o,
  output logic empty_o,
  output logic busy_o
);

  logic [1:0] valid_q;
  logic [1:0] owner_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= 2'b00;
      owner_q <= 2'b00;
    end else begin
      valid_q <= {valid_q[0], push_i};
      owner_q <= {owner_q[0], owner_i};
    end
  end

  assign eng_rsp_valid_o = valid_q[1] & (owner_q[1] == OWN_ENG);
  assign wbs_rsp_valid_o = valid_q[1] & (owner_q[1] == OWN_WBS);

  // Stage 2 always retires to its tagged owner, so once stage 1 is clear
  // nothing remains in flight past this edge and a mode change is safe.
  assign empty_o = ~valid_q[0];
  assign busy_o  = |valid_q;

endmodule

// File: rtl/qp_mem_arbiter.sv
// Round-robin arbiter sharing the single-port query-patch SRAM between the
// Wishbone debug controller and the ANN engine, with drained debug lockout.
module qp_mem_arbiter
  import qp_arb_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_debug,
  input  logic              wbs_req_valid,
  output logic              wbs_req_ready,
  input  logic              wbs_req_we,
  input  logic [ADDRW-1:0]  wbs_req_addr,
  input  logic [PATCHW-1:0] wbs_req_wpatch,
  output logic              wbs_rsp_valid,
  output logic [PATCHW-1:0] wbs_rsp_rpatch,
  input  logic              eng_req_valid,
  output logic              eng_req_ready,
  input  logic              eng_req_we,
  input  logic [ADDRW-1:0]  eng_req_addr,
  input  logic [PATCHW-1:0] eng_req_wpatch,
  output logic              eng_rsp_valid,
  output logic [PATCHW-1:0] eng_rsp_rpatch,
  output logic              mem_csb0,
  output logic              mem_web0,
  output logic [ADDRW-1:0]  mem_addr0,
  output logic [PATCHW-1:0] mem_wpatch0,
  input  logic [PATCHW-1:0] mem_rpatch0,
  output logic              arb_busy
);

  arb_state_e       state_q, state_d;
  owner_e           rr_q, rr_d;
  logic             csb_q, csb_d;
  logic             web_q, web_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  patch_t           wpatch_q, wpatch_d;

  logic wbs_acc, eng_acc, any_acc, sel_we, pipe_empty, pipe_busy;

  // Readies look only at state, valids and the rr pointer.
  always_comb begin
    wbs_req_ready = 1'b0;
    eng_req_ready = 1'b0;
    if (!wb_rst_i) begin
      case (state_q)
        NORMAL: begin
          eng_req_ready = eng_req_valid & (~wbs_req_valid | (rr_q == OWN_WBS));
          wbs_req_ready = wbs_req_valid & (~eng_req_valid | (rr_q == OWN_ENG));
        end
        DEBUG:   wbs_req_ready = wbs_req_valid;
        default: ;
      endcase
    end
  end

  assign wbs_acc = wbs_req_valid & wbs_req_ready;
  assign eng_acc = eng_req_valid & eng_req_ready;
  assign any_acc = wbs_acc | eng_acc;
  assign sel_we  = eng_acc ? eng_req_we : wbs_req_we;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    addr_d   = addr_q;
    wpatch_d = wpatch_q;
    // The pointer only moves when both sides actually contended.
    if (state_q == NORMAL && wbs_req_valid && eng_req_valid)
      rr_d = eng_acc ? OWN_ENG : OWN_WBS;
    if (any_acc) begin
      csb_d    = 1'b0;
      web_d    = ~sel_we;
      addr_d   = eng_acc ? eng_req_addr : wbs_req_addr;
      wpatch_d = eng_acc ? patch_t'(eng_req_wpatch) : patch_t'(wbs_req_wpatch);
    end
    case (state_q)
      NORMAL: if (wbs_debug) state_d = DRAIN_TO_DEBUG;
      DEBUG:  if (!wbs_debug) state_d = DRAIN_TO_NORMAL;
      default: begin
        // A drain always heads toward whatever wbs_debug currently asks for.
        if (pipe_empty) state_d = wbs_debug ? DEBUG : NORMAL;
        else            state_d = wbs_debug ? DRAIN_TO_DEBUG : DRAIN_TO_NORMAL;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= NORMAL;
      rr_q     <= OWN_WBS;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      addr_q   <= '0;
      wpatch_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      wpatch_q <= wpatch_d;
    end
  end

  qp_rsp_pipe u_rsp_pipe (
    .clk_i           (wb_clk_i),
    .srst_i          (wb_rst_i),
    .push_i          (any_acc & ~sel_we),
    .owner_i         (eng_acc),
    .wbs_rsp_valid_o (wbs_rsp_valid),
    .eng_rsp_valid_o (eng_rsp_valid),
    .empty_o         (pipe_empty),
    .busy_o          (pipe_busy)
  );

  assign mem_csb0       = csb_q;
  assign mem_web0       = web_q;
  assign mem_addr0      = addr_q;
  assign mem_wpatch0    = wpatch_q;
  assign wbs_rsp_rpatch = mem_rpatch0;
  assign eng_rsp_rpatch = mem_rpatch0;
  assign arb_busy       = pipe_busy | is_drain(state_q);

endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Directed bench for qp_mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_qp_mem_arbiter;

  localparam int AW = 9;
  localparam int PW = 55;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dbg = 1'b0;
  logic          wv = 1'b0, we = 1'b0, ev = 1'b0, ee = 1'b0;
  logic [AW-1:0] wa = '0, ea = '0;
  logic [PW-1:0] wd = '0, ed = '0;
  logic          wr, er, wrv, erv;
  logic [PW-1:0] wrp, erp;
  logic          mem_csb0, mem_web0, busy;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0;
  logic [PW-1:0] mem_rpatch0 = '0;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] wr_data [0:511];
  bit            wr_flag [0:511];

  always #5 clk = ~clk;

  qp_mem_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_debug(dbg),
    .wbs_req_valid(wv), .wbs_req_ready(wr), .wbs_req_we(we),
    .wbs_req_addr(wa), .wbs_req_wpatch(wd),
    .wbs_rsp_valid(wrv), .wbs_rsp_rpatch(wrp),
    .eng_req_valid(ev), .eng_req_ready(er), .eng_req_we(ee),
    .eng_req_addr(ea), .eng_req_wpatch(ed),
    .eng_rsp_valid(erv), .eng_rsp_rpatch(erp),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_wpatch0(mem_wpatch0), .mem_rpatch0(mem_rpatch0),
    .arb_busy(busy)
  );

  function automatic logic [PW-1:0] pat(int a);
    if (a == 5) return 55'h00_1010_DEAD_BEEF;
    return PW'(a * 1009 + 7);
  endfunction

  always @(posedge clk) begin
    if (!mem_csb0) begin
      if (!mem_web0) begin
        wr_flag[mem_addr0] <= 1'b1;
        wr_data[mem_addr0] <= mem_wpatch0;
      end else begin
        mem_rpatch0 <= wr_flag[mem_addr0] ? wr_data[mem_addr0] : pat(int'(mem_addr0));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] wdat;
    wdat = 55'h0B_CDEF_0123_4567;

    // Reset with both valids high: readies must still be low.
    wv = 1'b1; ev = 1'b1;
    step(); #1;
    check("rst_csb", 64'(mem_csb0), 64'd1);
    check("rst_web", 64'(mem_web0), 64'd1);
    check("rst_addr", 64'(mem_addr0), 64'd0);
    check("rst_wpatch", 64'(mem_wpatch0), 64'd0);
    check("rst_rsp", 64'({wrv, erv}), 64'd0);
    check("rst_rdy", 64'({wr, er}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0; wv = 1'b0; ev = 1'b0;
    step();

    // Single engine read of address 5.
    ev = 1'b1; ee = 1'b0; ea = 9'd5; #1;
    check("t1_rdy", 64'({wr, er}), 64'b01);
    step(); ev = 1'b0; #1;
    check("t1_issue", 64'({mem_csb0, mem_web0, mem_addr0}), 64'({1'b0, 1'b1, 9'd5}));
    check("t1_early", 64'(erv), 64'd0);
    step(); #1;
    check("t1_erv", 64'({wrv, erv}), 64'b01);
    check("t1_data", 64'(erp), 64'(55'h00_1010_DEAD_BEEF));
    step();

    // Contention: grants alternate ENG, WBS, ENG, ...
    for (int i = 0; i < 8; i++) begin
      bit e;
      int a;
      wv = (i < 6); ev = (i < 6); we = 1'b0; ee = 1'b0;
      wa = AW'(10 + i); ea = AW'(20 + i);
      #1;
      if (i < 6) check($sformatf("t2_rdy%0d", i), 64'({wr, er}), (i % 2 == 0) ? 64'b01 : 64'b10);
      if (i >= 1 && i <= 6) begin
        e = ((i - 1) % 2 == 0);
        a = e ? 20 + i - 1 : 10 + i - 1;
        check($sformatf("t2_addr%0d", i), 64'({mem_csb0, mem_addr0}), 64'({1'b0, AW'(a)}));
      end
      if (i >= 2) begin
        e = ((i - 2) % 2 == 0);
        a = e ? 20 + i - 2 : 10 + i - 2;
        check($sformatf("t2_rsp%0d", i), 64'({wrv, erv}), e ? 64'b01 : 64'b10);
        check($sformatf("t2_data%0d", i), 64'(e ? erp : wrp), 64'(pat(a)));
      end
      step();
    end

    // Engine read accepted as debug is requested: drain, then lockout.
    ev = 1'b1; ea = 9'd7; dbg = 1'b1; #1;
    check("t3_acc", 64'(er), 64'd1);
    step(); wv = 1'b1; wa = 9'd3; #1;
    check("t3_drain1", 64'({wr, er, busy}), 64'b001);
    step(); #1;
    check("t3_drain2", 64'({wr, er}), 64'b00);
    check("t3_rsp", 64'({wrv, erv}), 64'b01);
    check("t3_data", 64'(erp), 64'(pat(7)));
    step();
    we = 1'b1; wa = 9'd2; wd = wdat; #1;
    check("t3_debug", 64'({wr, er}), 64'b10);

    // Debug write then readback of address 2.
    step(); ev = 1'b0; we = 1'b0; #1;
    check("t4_wr", 64'({mem_csb0, mem_web0, mem_addr0}), 64'({1'b0, 1'b0, 9'd2}));
    check("t4_wdata", 64'(mem_wpatch0), 64'(wdat));
    step(); wv = 1'b0; #1;
    check("t4_rd", 64'({mem_csb0, mem_web0}), 64'b01);
    check("t4_norsp", 64'({wrv, erv}), 64'b00);
    step(); #1;
    check("t4_rsp", 64'({wrv, erv}), 64'b10);
    check("t4_data", 64'(wrp), 64'(wdat));

    // Leave debug, then abort a drain toward debug.
    dbg = 1'b0; step(); step();
    ev = 1'b1; ea = 9'd9; dbg = 1'b1; #1;
    check("t5_acc", 64'(er), 64'd1);
    step(); dbg = 1'b0; #1;
    check("t5_drain1", 64'(er), 64'd0);
    step(); #1;
    check("t5_drain2", 64'(er), 64'd0);
    check("t5_rsp", 64'({wrv, erv}), 64'b01);
    check("t5_data", 64'(erp), 64'(pat(9)));
    step(); ea = 9'd11; #1;
    check("t5_normal", 64'(er), 64'd1);

    // Reset one cycle after a read accept.
    step(); ev = 1'b0; rst = 1'b1; #1;
    check("t6_issue", 64'(mem_csb0), 64'd0);
    step(); rst = 1'b0; #1;
    check("t6_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_rsp%0d", k), 64'({wrv, erv}), 64'b00);
      check($sformatf("t6_csb%0d", k), 64'(mem_csb0), 64'd1);
      step(); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
